// File: rtl/axc_abs_diff_wce_sweeper_pkg.sv
// Shared types and width helpers for the approximate |a-b| error sweeper.
// Widths are derived from the operand and result widths so that nothing can overflow on a full sweep.
package axc_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_DONE
    } sweep_state_e;

    function automatic int vec_w(input int in_w);
        return 2 * in_w;
    endfunction

    function automatic int sum_w(input int in_w, input int out_w);
        return 2 * in_w + out_w;
    endfunction

    function automatic int cnt_w(input int in_w);
        return 2 * in_w + 1;
    endfunction

endpackage

// File: rtl/axc_abs_diff_wce_sweeper_if.sv
// Control, unit-under-test and statistics bundle of the sweeper.
// The sweeper is the slave; the characterisation host is the master.
interface axc_abs_diff_wce_sweeper_if
    import axc_sweep_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4
);
    logic                           start;
    logic                           abort;
    logic [vec_w(IN_W)-1:0]         dut_pi;
    logic [OUT_W-1:0]               dut_po;
    logic                           busy;
    logic                           done;
    logic                           aborted;
    logic [OUT_W-1:0]               max_err;
    logic [sum_w(IN_W, OUT_W)-1:0]  err_sum;
    logic [cnt_w(IN_W)-1:0]         viol_cnt;
    logic [vec_w(IN_W)-1:0]         first_viol_vec;
    logic                           first_viol_valid;

    modport slave (
        input  start, abort, dut_po,
        output dut_pi, busy, done, aborted, max_err, err_sum, viol_cnt,
               first_viol_vec, first_viol_valid
    );

    modport master (
        output start, abort, dut_po,
        input  dut_pi, busy, done, aborted, max_err, err_sum, viol_cnt,
               first_viol_vec, first_viol_valid
    );
endinterface

// File: rtl/axc_abs_diff_wce_sweeper_exact.sv
// Combinational golden |a-b| for a packed {a, b} vector.
// Kept as its own module so it can also serve as a reference unit on the bench.
module axc_abs_diff_exact
    import axc_sweep_pkg::*;
#(
    parameter int IN_W = 4
) (
    input  logic [vec_w(IN_W)-1:0] vec,
    output logic [IN_W-1:0]        abs_diff
);
    logic [IN_W-1:0] a;
    logic [IN_W-1:0] b;

    assign a        = vec[2*IN_W-1:IN_W];
    assign b        = vec[IN_W-1:0];
    assign abs_diff = (a >= b) ? (a - b) : (b - a);
endmodule

// File: rtl/axc_abs_diff_wce_sweeper.sv
// Sweeps every input vector 0..LAST_VEC through an approximate |a-b| unit and
// accumulates worst-case error, error sum, bound violations and first violating vector.
module axc_abs_diff_wce_sweeper
    import axc_sweep_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int OUT_W    = 4,
    parameter int WC_BOUND = 4,
    parameter int LAST_VEC = 2**(2*IN_W) - 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axc_abs_diff_wce_sweeper_if.slave sw
);
    localparam int VEC_W = vec_w(IN_W);
    localparam int SUM_W = sum_w(IN_W, OUT_W);
    localparam int CNT_W = cnt_w(IN_W);
    localparam logic [VEC_W-1:0] LAST  = VEC_W'(LAST_VEC);
    localparam logic [OUT_W-1:0] BOUND = OUT_W'(WC_BOUND);

    function automatic logic [OUT_W-1:0] abs_err(input logic [IN_W-1:0]  exact_val,
                                                 input logic [OUT_W-1:0] approx_val);
        logic signed [OUT_W:0] diff;
        diff = $signed({1'b0, OUT_W'(exact_val)}) - $signed({1'b0, approx_val});
        return (diff < 0) ? OUT_W'(-diff) : OUT_W'(diff);
    endfunction

    sweep_state_e state_q, state_d;
    logic             accept, kill, advance;
    logic [VEC_W-1:0] dut_pi_q;
    logic [IN_W-1:0]  exact;
    logic             vld_p1;
    logic [VEC_W-1:0] vec_p1;
    logic [IN_W-1:0]  exact_p1;
    logic [OUT_W-1:0] po_p1;
    logic [OUT_W-1:0] err_p2;
    logic [OUT_W-1:0] max_err_q;
    logic [SUM_W-1:0] err_sum_q;
    logic [CNT_W-1:0] viol_cnt_q;
    logic [VEC_W-1:0] first_vec_q;
    logic             first_vld_q;
    logic             aborted_q;

    axc_abs_diff_exact #(.IN_W(IN_W)) u_exact (
        .vec      (dut_pi_q),
        .abs_diff (exact)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        kill    = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                accept = sw.start && !sw.abort;
                if (accept) state_d = ST_SWEEP;
            end
            ST_SWEEP: begin
                kill    = sw.abort;
                advance = !sw.abort;
                if (sw.abort)              state_d = ST_IDLE;
                else if (dut_pi_q == LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                kill    = sw.abort;
                state_d = sw.abort ? ST_IDLE : ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Stage 1: vector generation and capture of {vector, exact, approx}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_pi_q <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= advance;
            if (accept)                        dut_pi_q <= '0;
            else if (advance && dut_pi_q != LAST) dut_pi_q <= dut_pi_q + VEC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            vec_p1   <= dut_pi_q;
            exact_p1 <= exact;
            po_p1    <= sw.dut_po;
        end
    end

    assign err_p2 = abs_err(exact_p1, po_p1);

    // Stage 2: statistics accumulation; an abort discards the in-flight vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_err_q   <= '0;
            err_sum_q   <= '0;
            viol_cnt_q  <= '0;
            first_vec_q <= '0;
            first_vld_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else if (accept) begin
            max_err_q   <= '0;
            err_sum_q   <= '0;
            viol_cnt_q  <= '0;
            first_vec_q <= '0;
            first_vld_q <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            if (kill) aborted_q <= 1'b1;
            if (vld_p1 && !kill) begin
                if (err_p2 > max_err_q) max_err_q <= err_p2;
                err_sum_q <= err_sum_q + SUM_W'(err_p2);
                if (err_p2 > BOUND) begin
                    viol_cnt_q <= viol_cnt_q + CNT_W'(1);
                    if (!first_vld_q) begin
                        first_vec_q <= vec_p1;
                        first_vld_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign sw.dut_pi           = dut_pi_q;
    assign sw.busy             = (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    assign sw.done             = (state_q == ST_DONE);
    assign sw.aborted          = aborted_q;
    assign sw.max_err          = max_err_q;
    assign sw.err_sum          = err_sum_q;
    assign sw.viol_cnt         = viol_cnt_q;
    assign sw.first_viol_vec   = first_vec_q;
    assign sw.first_viol_valid = first_vld_q;
endmodule

// File: tb/tb_axc_abs_diff_wce_sweeper.sv
// Bench for the error sweeper: behavioural units under test and a loop-based statistics model.
module tb_axc_abs_diff_wce_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   mode   = 0;
    logic [3:0] lut [256];

    int m_max, m_sum, m_viol, m_first, m_fvv;

    always #5 clk = ~clk;

    axc_abs_diff_wce_sweeper_if #(.IN_W(4), .OUT_W(4)) if0 ();
    axc_abs_diff_wce_sweeper_if #(.IN_W(4), .OUT_W(4)) if1 ();

    axc_abs_diff_wce_sweeper #(.IN_W(4), .OUT_W(4), .WC_BOUND(4)) u0 (
        .clk(clk), .rst_n(rst_n), .sw(if0)
    );
    axc_abs_diff_wce_sweeper #(.IN_W(4), .OUT_W(4), .WC_BOUND(4), .LAST_VEC(8'h63)) u1 (
        .clk(clk), .rst_n(rst_n), .sw(if1)
    );

    function automatic int exact_of(input logic [7:0] v);
        int a, b;
        a = int'(v[7:4]);
        b = int'(v[3:0]);
        return (a > b) ? a - b : b - a;
    endfunction

    // Behavioural approximate units: 0 exact, 1 zero, 2 exact+4 sat, 3 exact+5 sat, 4 random table
    function automatic logic [3:0] unit_po(input int m, input logic [7:0] v);
        int e;
        e = exact_of(v);
        case (m)
            0:       return 4'(e);
            1:       return 4'd0;
            2:       return 4'((e + 4 > 15) ? 15 : e + 4);
            3:       return 4'((e + 5 > 15) ? 15 : e + 5);
            default: return lut[v];
        endcase
    endfunction

    assign if0.dut_po = unit_po(mode, if0.dut_pi);
    assign if1.dut_po = unit_po(0, if1.dut_pi);

    task automatic model(input int m, input int last);
        int e;
        m_max = 0; m_sum = 0; m_viol = 0; m_first = 0; m_fvv = 0;
        for (int v = 0; v <= last; v++) begin
            e = exact_of(8'(v)) - int'(unit_po(m, 8'(v)));
            if (e < 0) e = -e;
            if (e > m_max) m_max = e;
            m_sum += e;
            if (e > 4) begin
                m_viol++;
                if (m_fvv == 0) begin m_first = v; m_fvv = 1; end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stats0(input string tag);
        chk({tag, "_max_err"}, 64'(if0.max_err), 64'(m_max));
        chk({tag, "_err_sum"}, 64'(if0.err_sum), 64'(m_sum));
        chk({tag, "_viol_cnt"}, 64'(if0.viol_cnt), 64'(m_viol));
        chk({tag, "_fv_valid"}, 64'(if0.first_viol_valid), 64'(m_fvv));
        if (m_fvv != 0) chk({tag, "_fv_vec"}, 64'(if0.first_viol_vec), 64'(m_first));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 64'(if0.busy), 0);
        chk({tag, "_done"}, 64'(if0.done), 0);
        chk({tag, "_aborted"}, 64'(if0.aborted), 0);
        chk({tag, "_dut_pi"}, 64'(if0.dut_pi), 0);
        chk({tag, "_max_err"}, 64'(if0.max_err), 0);
        chk({tag, "_err_sum"}, 64'(if0.err_sum), 0);
        chk({tag, "_viol_cnt"}, 64'(if0.viol_cnt), 0);
        chk({tag, "_fv_vec"}, 64'(if0.first_viol_vec), 0);
        chk({tag, "_fv_valid"}, 64'(if0.first_viol_valid), 0);
    endtask

    // Full sweep on u0; also pokes start while busy and during DONE, both of which must be ignored
    task automatic run0(input int m, input string tag);
        int cyc, dcyc, bcnt;
        mode = m;
        model(m, 255);
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        cyc = 1; dcyc = 0; bcnt = 0;
        chk({tag, "_c1_aborted"}, 64'(if0.aborted), 0);
        chk({tag, "_c1_err_sum"}, 64'(if0.err_sum), 0);
        while (dcyc == 0 && cyc < 400) begin
            if (if0.busy) bcnt++;
            if (if0.done) dcyc = cyc;
            else begin
                if (cyc == 30) if0.start = 1'b1;
                @(negedge clk);
                if0.start = 1'b0;
                cyc++;
            end
        end
        chk({tag, "_done_cycle"}, 64'(dcyc), 258);
        chk({tag, "_busy_cycles"}, 64'(bcnt), 257);
        chk({tag, "_dut_pi_end"}, 64'(if0.dut_pi), 8'hff);
        chk_stats0(tag);
        if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        chk({tag, "_post_done"}, 64'(if0.done), 0);
        chk({tag, "_post_busy"}, 64'(if0.busy), 0);
        @(negedge clk);
        chk({tag, "_post2_busy"}, 64'(if0.busy), 0);
        chk({tag, "_hold_err_sum"}, 64'(if0.err_sum), 64'(m_sum));
    endtask

    initial begin
        int cyc, dcyc, bcnt, seen;
        rst_n = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        if1.start = 1'b0; if1.abort = 1'b0;
        for (int i = 0; i < 256; i++) lut[i] = 4'd0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run0(0, "exact");
        run0(1, "zero");
        chk("zero_const_sum", 64'(m_sum), 1360);
        chk("zero_const_viol", 64'(if0.viol_cnt), 132);
        chk("zero_const_first", 64'(if0.first_viol_vec), 8'h05);

        // Short sweep on u1
        @(negedge clk); if1.start = 1'b1;
        @(negedge clk); if1.start = 1'b0;
        cyc = 1; dcyc = 0; bcnt = 0;
        while (dcyc == 0 && cyc < 400) begin
            if (if1.busy) bcnt++;
            if (if1.done) dcyc = cyc;
            else begin @(negedge clk); cyc++; end
        end
        chk("short_done_cycle", 64'(dcyc), 102);
        chk("short_busy_cycles", 64'(bcnt), 101);
        chk("short_dut_pi_end", 64'(if1.dut_pi), 8'h63);
        chk("short_max_err", 64'(if1.max_err), 0);
        chk("short_err_sum", 64'(if1.err_sum), 0);
        chk("short_viol_cnt", 64'(if1.viol_cnt), 0);
        chk("short_fv_valid", 64'(if1.first_viol_valid), 0);

        // Abort during cycle 50: vectors 0..47 have reached the statistics, vector 48 is discarded
        mode = 1;
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        repeat (49) @(negedge clk);
        if0.abort = 1'b1;
        @(negedge clk); if0.abort = 1'b0;
        chk("abort_busy", 64'(if0.busy), 0);
        chk("abort_aborted", 64'(if0.aborted), 1);
        model(1, 47);
        chk_stats0("abort_partial");
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if0.done || if0.busy) seen++;
        end
        chk("abort_no_done", 64'(seen), 0);
        run0(1, "restart");

        // Asynchronous reset mid-sweep in cycle 100
        mode = 1;
        @(negedge clk); if0.start = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        repeat (99) @(negedge clk);
        chk("pre_reset_busy", 64'(if0.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midreset");
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (if0.done || if0.busy) seen++;
        end
        chk("midreset_no_done", 64'(seen), 0);

        // start together with abort in IDLE must not launch a sweep
        if0.start = 1'b1; if0.abort = 1'b1;
        @(negedge clk); if0.start = 1'b0; if0.abort = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (if0.busy) seen++;
            @(negedge clk);
        end
        chk("start_abort_idle", 64'(seen), 0);
        chk("start_abort_aborted", 64'(if0.aborted), 0);

        run0(2, "plus4");
        chk("plus4_const_max", 64'(if0.max_err), 4);
        chk("plus4_const_viol", 64'(if0.viol_cnt), 0);
        run0(3, "plus5");
        chk("plus5_const_first", 64'(if0.first_viol_vec), 8'h00);
        chk("plus5_const_valid", 64'(if0.first_viol_valid), 1);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 256; i++) lut[i] = 4'($urandom_range(0, 15));
            run0(4, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
